// File: rtl/rf_bist_pkg.sv
// rf_bist_pkg: shared FSM encoding and pattern constants for the register-file BIST.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

package rf_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic PAT_INV = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rf_bist_pattern.sv
// rf_bist_pattern: combinational expected-data generator exp(pat, addr).
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module rf_bist_pattern #(
  parameter int              ADDR_W  = 4,
  parameter int              DATA_W  = 32,
  parameter logic [DATA_W-1:0] SEED  = '0,
  parameter bit              ZERO_R0 = 1'b0
) (
  input  logic              pat,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] exp_data
);
  import rf_bist_pkg::*;

  logic [DATA_W-1:0] sum;

  assign sum = SEED + DATA_W'(addr);

  always_comb begin
    exp_data = (pat == PAT_INV) ? ~sum : sum;
    // A hardwired r0 always reads back zero whatever was written.
    if (ZERO_R0 && (addr == '0)) exp_data = '0;
  end

endmodule

`default_nettype wire

// File: rtl/rf_bist_ctrl.sv
// rf_bist_ctrl: two-pattern write/read BIST initiator for the register file.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module rf_bist_ctrl #(
  parameter int                NREGS   = 16,
  parameter int                ADDR_W  = 4,
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] SEED    = '0,
  parameter bit                ZERO_R0 = 1'b0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [1:0]        fail_port,
  output logic              WrEn,
  output logic [ADDR_W-1:0] RD,
  output logic [DATA_W-1:0] DataIn,
  output logic [ADDR_W-1:0] RS1,
  output logic [ADDR_W-1:0] RS2,
  input  logic [DATA_W-1:0] out1,
  input  logic [DATA_W-1:0] out2
);
  import rf_bist_pkg::*;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic              pat, pat_nxt;
  logic [ADDR_W-1:0] rs2_addr;
  logic [DATA_W-1:0] exp1, exp2;
  logic [1:0]        mism;
  logic              clear_res, set_pass, set_fail;

  assign rs2_addr = LAST - addr;

  // The RS1 instance also produces write data, since RD and RS1 both follow addr.
  rf_bist_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEED(SEED), .ZERO_R0(ZERO_R0)) u_pat1 (
    .pat(pat), .addr(addr), .exp_data(exp1)
  );

  rf_bist_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SEED(SEED), .ZERO_R0(ZERO_R0)) u_pat2 (
    .pat(pat), .addr(rs2_addr), .exp_data(exp2)
  );

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    pat_nxt   = pat;
    busy      = 1'b0;
    done      = 1'b0;
    WrEn      = 1'b0;
    RD        = '0;
    DataIn    = '0;
    RS1       = '0;
    RS2       = '0;
    mism      = 2'b00;
    clear_res = 1'b0;
    set_pass  = 1'b0;
    set_fail  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_WRITE;
          addr_nxt  = '0;
          pat_nxt   = 1'b0;
          clear_res = 1'b1;
        end
      end
      ST_WRITE: begin
        busy   = 1'b1;
        WrEn   = 1'b1;
        RD     = addr;
        DataIn = exp1;
        if (addr == LAST) begin
          state_nxt = ST_READ;
          addr_nxt  = '0;
        end else begin
          addr_nxt = addr + 1'b1;
        end
      end
      ST_READ: begin
        busy = 1'b1;
        RS1  = addr;
        RS2  = rs2_addr;
        mism = {out2 != exp2, out1 != exp1};
        if (mism != 2'b00) begin
          state_nxt = ST_DONE;
          set_fail  = 1'b1;
        end else if (addr == LAST) begin
          addr_nxt = '0;
          if (pat == PAT_INV) begin
            state_nxt = ST_DONE;
            set_pass  = 1'b1;
          end else begin
            state_nxt = ST_WRITE;
            pat_nxt   = PAT_INV;
          end
        end else begin
          addr_nxt = addr + 1'b1;
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      addr      <= '0;
      pat       <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_port <= 2'b00;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
      pat   <= pat_nxt;
      if (clear_res) begin
        pass      <= 1'b0;
        fail_addr <= '0;
        fail_port <= 2'b00;
      end
      if (set_pass) pass <= 1'b1;
      if (set_fail) begin
        pass      <= 1'b0;
        fail_port <= mism;
        fail_addr <= mism[0] ? addr : rs2_addr;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rf_bist_ctrl.sv
// tb_rf_bist_ctrl: checks the BIST against faulty behavioural register files.
// Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module tb_rf_bist_ctrl;

  localparam logic [31:0] SEED_B = 32'hA5A5_0F0F;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0;
  logic busy_a, done_a, pass_a, wren_a, busy_b, done_b, pass_b, wren_b;
  logic [3:0] fa_a, rd_a, rs1_a, rs2_a, fa_b, rd_b, rs1_b, rs2_b;
  logic [1:0] fp_a, fp_b;
  logic [31:0] din_a, out1_a, out2_a, din_b, out1_b, out2_b;

  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  logic clr = 1'b0;

  logic ign_wr = 1'b0, hard_r0 = 1'b0, stuck_en = 1'b0, stuck_val = 1'b0;
  logic [3:0] stuck_reg = '0;
  logic [4:0] stuck_bit = '0;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  rf_bist_ctrl #(.NREGS(16), .ADDR_W(4), .DATA_W(32), .SEED(32'h0), .ZERO_R0(1'b0)) dut_a (
    .CLK(CLK), .RESET(RESET), .start(start_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_addr(fa_a), .fail_port(fp_a), .WrEn(wren_a), .RD(rd_a), .DataIn(din_a),
    .RS1(rs1_a), .RS2(rs2_a), .out1(out1_a), .out2(out2_a)
  );

  rf_bist_ctrl #(.NREGS(16), .ADDR_W(4), .DATA_W(32), .SEED(SEED_B), .ZERO_R0(1'b1)) dut_b (
    .CLK(CLK), .RESET(RESET), .start(start_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_addr(fa_b), .fail_port(fp_b), .WrEn(wren_b), .RD(rd_b), .DataIn(din_b),
    .RS1(rs1_b), .RS2(rs2_b), .out1(out1_b), .out2(out2_b)
  );

  // Faulty register file read path: optional stuck bit, optional hardwired r0.
  function automatic logic [31:0] fault_read(input logic [3:0] a, input logic [31:0] raw);
    logic [31:0] v;
    v = raw;
    if (stuck_en && a == stuck_reg) v[stuck_bit] = stuck_val;
    if (hard_r0 && a == 4'd0) v = '0;
    return v;
  endfunction

  always @(posedge CLK) begin
    if (clr) begin
      for (int i = 0; i < 16; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
      end
    end else begin
      if (wren_a && !ign_wr) mem_a[rd_a] <= din_a;
      if (wren_b && !ign_wr) mem_b[rd_b] <= din_b;
    end
  end

  always_comb begin
    out1_a = fault_read(rs1_a, mem_a[rs1_a]);
    out2_a = fault_read(rs2_a, mem_a[rs2_a]);
    out1_b = fault_read(rs1_b, mem_b[rs1_b]);
    out2_b = fault_read(rs2_b, mem_b[rs2_b]);
  end

  // Reference model: expected word and whole-run outcome computed directly.
  function automatic logic [31:0] expf(input bit sel, input int p, input int a);
    logic [31:0] s;
    s = (sel ? SEED_B : 32'h0) + 32'(a);
    if (sel && a == 0) return 32'h0;
    return (p == 0) ? s : ~s;
  endfunction

  typedef struct packed {
    logic       pass;
    logic [3:0] fa;
    logic [1:0] fp;
    logic [7:0] cyc;
  } res_t;

  function automatic res_t predict(input bit sel);
    logic [31:0] m [16];
    res_t r;
    int   fpv;
    for (int i = 0; i < 16; i++) m[i] = '0;
    for (int p = 0; p < 2; p++) begin
      for (int a = 0; a < 16; a++) if (!ign_wr) m[a] = expf(sel, p, a);
      for (int a = 0; a < 16; a++) begin
        fpv = 0;
        if (fault_read(4'(a), m[a]) != expf(sel, p, a)) fpv |= 1;
        if (fault_read(4'(15 - a), m[15 - a]) != expf(sel, p, 15 - a)) fpv |= 2;
        if (fpv != 0) begin
          r.pass = 1'b0;
          r.fa   = (fpv & 1) ? 4'(a) : 4'(15 - a);
          r.fp   = 2'(fpv);
          r.cyc  = 8'(18 + 32 * p + a);
          return r;
        end
      end
    end
    r.pass = 1'b1; r.fa = '0; r.fp = '0; r.cyc = 8'd65;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  int          got_cyc, n_done, n_wr;
  logic        got_pass, hold_pass;
  logic [3:0]  got_fa, hold_fa;
  logic [1:0]  got_fp, hold_fp;
  logic [31:0] last_wr;

  // One run: clear RF, pulse start in cycle 0, observe cycles 1..100.
  task automatic run_bist(input bit sel, input bit extra);
    @(posedge CLK); #1 clr = 1'b1;
    @(posedge CLK); #1 clr = 1'b0;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    got_cyc = -1; n_done = 0; n_wr = 0; last_wr = '0;
    got_pass = 1'b0; got_fa = '0; got_fp = '0;
    for (int n = 1; n <= 100; n++) begin
      @(posedge CLK); #1;
      start_a = !sel && extra && (n == 5 || n == 40);
      start_b =  sel && extra && (n == 5 || n == 40);
      if (sel ? wren_b : wren_a) begin
        n_wr++;
        last_wr = sel ? din_b : din_a;
      end
      if (sel ? done_b : done_a) begin
        n_done++;
        if (got_cyc < 0) begin
          got_cyc  = n;
          got_pass = sel ? pass_b : pass_a;
          got_fa   = sel ? fa_b : fa_a;
          got_fp   = sel ? fp_b : fp_a;
        end
      end
    end
    hold_pass = sel ? pass_b : pass_a;
    hold_fa   = sel ? fa_b : fa_a;
    hold_fp   = sel ? fp_b : fp_a;
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic check_run(input string nm, input bit sel, input res_t r);
    chk({nm, " done_cycle"}, 32'(got_cyc), 32'(r.cyc));
    chk({nm, " done_count"}, 32'(n_done), 32'd1);
    chk({nm, " pass"}, 32'(got_pass), 32'(r.pass));
    chk({nm, " fail_addr"}, 32'(got_fa), 32'(r.fa));
    chk({nm, " fail_port"}, 32'(got_fp), 32'(r.fp));
    chk({nm, " held"}, {hold_pass, hold_fa, hold_fp}, {r.pass, r.fa, r.fp});
    chk({nm, " writes"}, 32'(n_wr), (r.cyc < 8'd50) ? 32'd16 : 32'd32);
    if (r.cyc >= 8'd50) chk({nm, " last_wr"}, last_wr, expf(sel, 1, 15));
  endtask

  typedef struct {
    bit sel; bit ign; bit hr0; bit sten; logic [3:0] sreg; logic [4:0] sbit; bit sval;
    bit pass; int fa; int fp; int cyc;
  } vec_t;

  vec_t tbl [6];
  res_t er;

  initial begin
    tbl[0] = '{0, 0, 0, 0, 4'd0, 5'd0, 0, 1, 0,  0, 65};  // good RF
    tbl[1] = '{0, 0, 0, 1, 4'd5, 5'd0, 0, 0, 5,  1, 23};  // r5 bit0 stuck-at-0
    tbl[2] = '{0, 1, 0, 0, 4'd0, 5'd0, 0, 0, 15, 2, 18};  // WrEn ignored
    tbl[3] = '{0, 0, 1, 0, 4'd0, 5'd0, 0, 0, 0,  1, 50};  // hardwired r0, ZERO_R0=0
    tbl[4] = '{1, 0, 1, 0, 4'd0, 5'd0, 0, 1, 0,  0, 65};  // hardwired r0, ZERO_R0=1
    tbl[5] = '{1, 0, 0, 0, 4'd0, 5'd0, 0, 1, 0,  0, 65};  // good RF, other seed

    // Reset with start asserted: reset must win.
    RESET = 1'b1; start_a = 1'b1; start_b = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_a", {busy_a, done_a, pass_a, fa_a, fp_a, wren_a, rd_a, rs1_a, rs2_a}, '0);
    chk("reset_a DataIn", din_a, '0);
    chk("reset_b", {busy_b, done_b, pass_b, fa_b, fp_b, wren_b, rd_b, rs1_b, rs2_b}, '0);
    chk("reset_b DataIn", din_b, '0);
    start_a = 1'b0; start_b = 1'b0;
    @(posedge CLK); #1 RESET = 1'b0;
    @(posedge CLK); #1;
    chk("idle after reset busy", {busy_a, busy_b}, 2'b00);

    for (int i = 0; i < 6; i++) begin
      ign_wr = tbl[i].ign; hard_r0 = tbl[i].hr0; stuck_en = tbl[i].sten;
      stuck_reg = tbl[i].sreg; stuck_bit = tbl[i].sbit; stuck_val = tbl[i].sval;
      er.pass = tbl[i].pass; er.fa = 4'(tbl[i].fa); er.fp = 2'(tbl[i].fp); er.cyc = 8'(tbl[i].cyc);
      run_bist(tbl[i].sel, 1'b0);
      check_run($sformatf("vec%0d", i), tbl[i].sel, er);
    end

    // Reset at cycle 10 of a run aborts it without a result.
    ign_wr = 0; hard_r0 = 0; stuck_en = 0;
    @(posedge CLK); #1 start_a = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge CLK); #1 start_a = 1'b0;
    end
    chk("midrun busy", 32'(busy_a), 32'd1);
    RESET = 1'b1;
    @(posedge CLK); #1;
    chk("abort state", {busy_a, wren_a, pass_a, done_a}, 4'b0000);
    RESET = 1'b0;
    er.pass = 1'b1; er.fa = '0; er.fp = '0; er.cyc = 8'd65;
    run_bist(1'b0, 1'b0);
    check_run("restart", 1'b0, er);

    // Extra start pulses while busy are ignored.
    run_bist(1'b0, 1'b1);
    check_run("start_while_busy", 1'b0, er);

    for (int k = 0; k < 20; k++) begin
      bit sel;
      sel       = 1'($urandom_range(0, 1));
      ign_wr    = ($urandom_range(0, 7) == 0);
      hard_r0   = ($urandom_range(0, 3) == 0);
      stuck_en  = 1'($urandom_range(0, 1));
      stuck_reg = 4'($urandom_range(0, 15));
      stuck_bit = 5'($urandom_range(0, 31));
      stuck_val = 1'($urandom_range(0, 1));
      er = predict(sel);
      run_bist(sel, 1'b0);
      check_run($sformatf("rand%0d", k), sel, er);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
